// File: rtl/morse_pkg.sv
// ============================================================================
// Module  : morse_pkg
// Brief   : Shared types and constants for the Morse encode/decode path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MARK     = 2'd1,
    GAP      = 2'd2,
    CHAR_GAP = 2'd3
  } state_t;

  localparam logic [5:0] CODE_SPACE     = 6'd36;
  localparam logic [5:0] CODE_MAX_VALID = 6'd36;

  // Durations in Morse units
  localparam logic [2:0] DOT_U      = 3'd1;
  localparam logic [2:0] DASH_U     = 3'd3;
  localparam logic [2:0] ELEM_GAP_U = 3'd1;
  localparam logic [2:0] CHAR_GAP_U = 3'd3;
  localparam logic [2:0] WORD_GAP_U = 3'd7;

endpackage

`default_nettype wire

// File: rtl/morse_rom.sv
// ============================================================================
// Module  : morse_rom
// Brief   : Character code to Morse pattern lookup (pat LSB first, 1 = dash).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] in_char,
  output logic       valid,
  output logic [2:0] len,
  output logic [4:0] pat
);

  always_comb begin
    valid = (in_char <= CODE_MAX_VALID);
    len   = 3'd0;
    pat   = 5'b00000;
    case (in_char)
      6'd0:  begin len = 3'd2; pat = 5'b00010; end // A .-
      6'd1:  begin len = 3'd4; pat = 5'b00001; end // B -...
      6'd2:  begin len = 3'd4; pat = 5'b00101; end
      6'd3:  begin len = 3'd3; pat = 5'b00001; end
      6'd4:  begin len = 3'd1; pat = 5'b00000; end
      6'd5:  begin len = 3'd4; pat = 5'b00100; end
      6'd6:  begin len = 3'd3; pat = 5'b00011; end
      6'd7:  begin len = 3'd4; pat = 5'b00000; end
      6'd8:  begin len = 3'd2; pat = 5'b00000; end
      6'd9:  begin len = 3'd4; pat = 5'b01110; end
      6'd10: begin len = 3'd3; pat = 5'b00101; end
      6'd11: begin len = 3'd4; pat = 5'b00010; end
      6'd12: begin len = 3'd2; pat = 5'b00011; end
      6'd13: begin len = 3'd2; pat = 5'b00001; end
      6'd14: begin len = 3'd3; pat = 5'b00111; end
      6'd15: begin len = 3'd4; pat = 5'b00110; end
      6'd16: begin len = 3'd4; pat = 5'b01011; end
      6'd17: begin len = 3'd3; pat = 5'b00010; end
      6'd18: begin len = 3'd3; pat = 5'b00000; end
      6'd19: begin len = 3'd1; pat = 5'b00001; end
      6'd20: begin len = 3'd3; pat = 5'b00100; end
      6'd21: begin len = 3'd4; pat = 5'b01000; end
      6'd22: begin len = 3'd3; pat = 5'b00110; end
      6'd23: begin len = 3'd4; pat = 5'b01001; end
      6'd24: begin len = 3'd4; pat = 5'b01101; end
      6'd25: begin len = 3'd4; pat = 5'b00011; end
      6'd26: begin len = 3'd5; pat = 5'b11111; end // 0 -----
      6'd27: begin len = 3'd5; pat = 5'b11110; end
      6'd28: begin len = 3'd5; pat = 5'b11100; end
      6'd29: begin len = 3'd5; pat = 5'b11000; end
      6'd30: begin len = 3'd5; pat = 5'b10000; end
      6'd31: begin len = 3'd5; pat = 5'b00000; end
      6'd32: begin len = 3'd5; pat = 5'b00001; end
      6'd33: begin len = 3'd5; pat = 5'b00011; end
      6'd34: begin len = 3'd5; pat = 5'b00111; end
      6'd35: begin len = 3'd5; pat = 5'b01111; end
      default: begin len = 3'd0; pat = 5'b00000; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/morse_encoder.sv
// ============================================================================
// Module  : morse_encoder
// Brief   : Sends one character code per handshake as a unit-timed Morse key.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 5000,
  parameter int CW          = $clog2(3*UNIT_CYCLES+1)
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [5:0] in_char,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [CW-1:0] UNIT_LD = CW'(UNIT_CYCLES);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_units;
  logic [2:0]    r_rem;
  logic [4:0]    r_pat;
  logic          r_key;
  logic          r_done;
  logic          r_err;

  logic       w_rom_valid;
  logic [2:0] w_rom_len;
  logic [4:0] w_rom_pat;
  logic       w_unit_end;
  logic       w_expire;
  logic [4:0] w_next_pat;

  morse_rom u_rom (
    .in_char (in_char),
    .valid   (w_rom_valid),
    .len     (w_rom_len),
    .pat     (w_rom_pat)
  );

  // Durations are counted as whole units times cycles-per-unit, so the
  // 7-unit word gap never has to fit in the cycle counter.
  assign w_unit_end = (r_cnt == CW'(1));
  assign w_expire   = w_unit_end && (r_units == 3'd1);
  assign w_next_pat = r_pat >> 1;

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_units <= 3'd0;
      r_rem   <= 3'd0;
      r_pat   <= 5'b00000;
      r_key   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state != IDLE) begin
        if (w_unit_end) begin
          r_cnt   <= UNIT_LD;
          r_units <= r_units - 3'd1;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (!w_rom_valid) begin
              r_err <= 1'b1;
            end else if (in_char == CODE_SPACE) begin
              r_state <= CHAR_GAP;
              r_cnt   <= UNIT_LD;
              r_units <= WORD_GAP_U;
            end else begin
              r_state <= MARK;
              r_key   <= 1'b1;
              r_cnt   <= UNIT_LD;
              r_pat   <= w_rom_pat;
              r_rem   <= w_rom_len;
              r_units <= w_rom_pat[0] ? DASH_U : DOT_U;
            end
          end
        end
        MARK: begin
          if (w_expire) begin
            r_key <= 1'b0;
            if (r_rem > 3'd1) begin
              r_state <= GAP;
              r_units <= ELEM_GAP_U;
            end else begin
              r_state <= CHAR_GAP;
              r_units <= CHAR_GAP_U;
            end
          end
        end
        GAP: begin
          if (w_expire) begin
            r_state <= MARK;
            r_key   <= 1'b1;
            r_pat   <= w_next_pat;
            r_rem   <= r_rem - 3'd1;
            r_units <= w_next_pat[0] ? DASH_U : DOT_U;
          end
        end
        CHAR_GAP: begin
          if (w_expire) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_out  = r_key;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = (r_state != IDLE);
  assign in_ready = (r_state == IDLE) && !rst;

endmodule

`default_nettype wire

// File: tb/tb_morse_encoder.sv
// ============================================================================
// Module  : tb_morse_encoder
// Brief   : Directed scoreboard bench for morse_encoder at UNIT_CYCLES = 4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_encoder;

  localparam int UNIT = 4;

  logic       clk_fast = 1'b0;
  logic       rst      = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_char  = 6'd0;
  logic       in_ready, key_out, busy, done, err;

  typedef struct packed {
    logic key;
    logic busy;
    logic done;
    logic err;
    logic rdy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                      "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                      "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                      "-.--", "--..", "-----", ".----", "..---", "...--",
                      "....-", ".....", "-....", "--...", "---..", "----."};

  morse_encoder #(.UNIT_CYCLES(UNIT)) dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_ready (in_ready),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk_fast = ~clk_fast;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic push_n(input int n, input exp_t e);
    repeat (n) sb.push_back(e);
  endtask

  // Expected per-cycle outputs from the cycle after the accept edge onwards.
  task automatic expect_char(input int code);
    exp_t  m  = '{key: 1'b1, busy: 1'b1, done: 1'b0, err: 1'b0, rdy: 1'b0};
    exp_t  g  = '{key: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0, rdy: 1'b0};
    exp_t  d  = '{key: 1'b0, busy: 1'b0, done: 1'b1, err: 1'b0, rdy: 1'b1};
    exp_t  er = '{key: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b1, rdy: 1'b1};
    string s;
    if (code <= 35) begin
      s = tbl[code];
      for (int i = 0; i < s.len(); i++) begin
        push_n((s.getc(i) == 8'h2D) ? 3*UNIT : UNIT, m);
        if (i < s.len() - 1) push_n(UNIT, g);
      end
      push_n(3*UNIT, g);
      sb.push_back(d);
    end else if (code == 36) begin
      push_n(7*UNIT, g);
      sb.push_back(d);
    end else begin
      sb.push_back(er);
    end
  endtask

  task automatic expect_idle(input int n);
    push_n(n, '{key: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0, rdy: 1'b1});
  endtask

  task automatic tick(input string tag);
    exp_t e;
    exp_t o;
    @(posedge clk_fast);
    #1;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      o = '{key: key_out, busy: busy, done: done, err: err, rdy: in_ready};
      checks++;
      assert (o === e) else begin
        failures++;
        $error("FAIL %s cyc=%0d {key,busy,done,err,rdy} observed=%b expected=%b",
               tag, cyc, o, e);
      end
    end
  endtask

  task automatic check1(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) tick(tag);
  endtask

  task automatic send(input string tag, input int code);
    in_valid = 1'b1;
    in_char  = 6'(code);
    expect_char(code);
    tick(tag);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check1("rst_key",  key_out, 1'b0);
    check1("rst_busy", busy,    1'b0);
    check1("rst_done", done,    1'b0);
    check1("rst_err",  err,     1'b0);
    @(posedge clk_fast);
    #1;
    rst = 1'b0;
    #1;
    check1("rst_rdy", in_ready, 1'b1);
    expect_idle(3);
    drain("idle");

    // E: single dot
    send("E", 4);
    drain("E");

    // A followed by T held on in_valid, accepted in A's done cycle
    in_valid = 1'b1;
    in_char  = 6'd0;
    expect_char(0);
    expect_char(19);
    tick("AT");
    in_char = 6'd19;
    repeat (32) tick("AT");
    tick("AT");
    in_valid = 1'b0;
    drain("AT");

    // Word space, then an invalid code
    send("SPACE", 36);
    drain("SPACE");
    send("INVALID", 50);
    expect_idle(3);
    drain("INVALID");

    // Digit 0 with in_valid toggled mid-character
    send("ZERO", 26);
    repeat (10) tick("ZERO");
    in_valid = 1'b1;
    in_char  = 6'd4;
    repeat (5) tick("ZERO");
    in_valid = 1'b0;
    repeat (5) tick("ZERO");
    in_valid = 1'b1;
    tick("ZERO");
    in_valid = 1'b0;
    drain("ZERO");
    expect_idle(4);
    drain("ZERO_after");

    // Reset mid-dash of A at cycle 10
    send("A_abort", 0);
    repeat (9) tick("A_abort");
    check1("pre_abort_key", key_out, 1'b1);
    rst = 1'b1;
    #1;
    check1("abort_key",  key_out,  1'b0);
    check1("abort_busy", busy,     1'b0);
    check1("abort_rdy",  in_ready, 1'b0);
    check1("abort_done", done,     1'b0);
    sb.delete();
    @(posedge clk_fast);
    #1;
    rst = 1'b0;
    expect_idle(3);
    drain("post_abort");
    send("E_after", 4);
    drain("E_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
